mcu_rd: RTL and testbench
=========================

Name: mcu_rd

Overview:
- MCU read-side responder for the eight-motor controller. It returns the data an external MCU fetches over its asynchronous CS/RD bus: motor busy status, sticky done flags and a coherent 32-bit position snapshot of a selected motor.
- It synchronizes the active-low MCU strobes into the CLK domain and runs a small read-cycle state machine.
- It drives the shared data bus with an output enable. It sits alongside the MCU write-side command decoder on the same address/data pins.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the RD_GBL synchronizer (minimum 2).
- VERSION, 8'hA5, constant returned at register address 6.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- CS  input  1  MCU chip select, active low, asynchronous.
- RD  input  1  MCU read strobe, active low, asynchronous.
- MCUportL  input  16  MCU address. [3:0] is the register index; [6:4] is the motor index for position reads.
- gBusy  input  8  per-motor busy level, CLK domain.
- gDonePls  input  8  per-motor one-cycle done pulses, CLK domain.
- gPosBus  input  32  position of the motor selected by gPosSel, valid one cycle after gPosSel changes.
- gPosSel  output  3  motor index driving the gPosBus mux, registered.
- Dout  output  8  read data.
- DoutEn  output  1  high while Dout must be driven onto the MCU bus.

Behaviour:
- RD_GBL = RD | CS, passed through SYNC_STAGES flip-flops plus one edge-detect register. All sync registers reset to 1.
- Start event: synchronized RD_GBL goes 1->0.
- End event: synchronized RD_GBL goes 0->1.
- Arm flag: reset to 0. Set once synchronized RD_GBL is sampled 1. Start events are ignored while the flag is 0, so a read already in progress at reset release is discarded.
- IDLE state:
  - On an armed start event, latch MCUportL[3:0] into addr_q and MCUportL[6:4] into gPosSel. Go to LOAD.
  - MCUportL is sampled only at this point and must be stable while RD is low.
- LOAD state (exactly 1 cycle):
  - Load Dout per addr_q and set DoutEn=1. Go to ACTIVE.
  - Address map:
    - 0: gBusy.
    - 1: done_flags.
    - 2: gPosBus[7:0]; in the same cycle capture snap <= gPosBus.
    - 3: snap[15:8].
    - 4: snap[23:16].
    - 5: snap[31:24].
    - 6: VERSION.
    - 7..15: 8'h00.
- ACTIVE state:
  - Dout and DoutEn are held constant.
  - On an end event: DoutEn <= 0, apply side effects, go to IDLE. Dout keeps its last value.
- Side effect at end of an addr-1 read: clear only the done_flags bits that were 1 in the returned Dout.
- done_flags update rule:
  - Each cycle: done_flags <= (done_flags & ~clr_mask) | gDonePls.
  - A set wins over a simultaneous clear.
  - A pulse arriving during ACTIVE stays set after the clear.
- Snapshot coherence:
  - snap changes only in LOAD with addr_q=2.
  - Reads of addresses 3..5 never update snap.
  - Reading address 2 with a different motor index re-captures snap for that motor.
- Latency: DoutEn rises SYNC_STAGES+2 CLK cycles after the RD_GBL falling edge and falls SYNC_STAGES+1 cycles after its rising edge.
- MCU timing requirement: RD low for at least SYNC_STAGES+4 CLK periods, and high for at least SYNC_STAGES+2 between reads.
- A strobe shorter than the synchronizer resolves as no event, or as a start/end pair. Either way the FSM returns to IDLE, with no partial state left.
- A start event seen in LOAD or ACTIVE is impossible by construction and is ignored.
- Reset values: Dout=8'h00, DoutEn=0, gPosSel=0, done_flags=0, snap=0, addr_q=0, state=IDLE, arm=0.
- Reset mid-read drops DoutEn to 0 in the next cycle and performs no clear.

Test Plan:
- Reset with RD=CS=0 held, then release -> no DoutEn until RD_GBL goes high; the next full read of addr 0 with gBusy=8'h3C returns Dout=8'h3C with DoutEn high.
- gDonePls pulses bits 0 and 5, then read addr 1 -> Dout=8'h21; after RD rises, done_flags=8'h00; a second read returns 8'h00.
- Pulse bit 2 while an addr-1 read (returned 8'h01) is ACTIVE -> after the end event done_flags=8'h04; a pulse on bit 0 coincident with the clear cycle leaves bit 0 set.
- Motor 3 position 32'h12345678: read addr 2 with MCUportL[6:4]=3 -> gPosSel=3, Dout=8'h78. Change gPosBus to 32'hFFFFFFFF, then read addrs 3, 4, 5 -> 8'h56, 8'h34, 8'h12.
- Read addr 6 -> Dout=8'hA5; read addr 9 -> 8'h00. Check DoutEn rise at SYNC_STAGES+2 and fall at SYNC_STAGES+1 cycles after the strobe edges.
- Assert RST during ACTIVE of an addr-1 read with done_flags=8'hFF -> DoutEn=0 and done_flags=0 next cycle; after release, the first read is accepted only after the strobe goes high.

Source files
------------

// File: rtl/mcu_rd.sv
// MCU read-side responder: synchronizes the async CS/RD strobe, serves busy,
// sticky done flags, version and a coherent 32-bit position snapshot.
module mcu_rd #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  VERSION     = 8'hA5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CS,
  input  logic        RD,
  input  logic [15:0] MCUportL,
  input  logic [7:0]  gBusy,
  input  logic [7:0]  gDonePls,
  input  logic [31:0] gPosBus,
  output logic [2:0]  gPosSel,
  output logic [7:0]  Dout,
  output logic        DoutEn
);

  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_rdPrev;
  logic                   r_arm;
  logic [3:0]             r_addr;
  logic [2:0]             r_posSel;
  logic [7:0]             r_dout;
  logic                   r_doutEn;
  logic [7:0]             r_doneFlags;
  logic [31:0]            r_snap;

  logic       w_rdGbl;
  logic       w_rdSync;
  logic       w_start;
  logic       w_end;
  logic       w_latch;
  logic       w_load;
  logic       w_finish;
  logic [7:0] w_loadData;
  logic [7:0] w_clrMask;
  logic       w_unused;

  assign w_rdGbl  = RD | CS;
  assign w_rdSync = r_sync[SYNC_STAGES-1];
  assign w_start  = r_rdPrev & ~w_rdSync & r_arm;
  assign w_end    = ~r_rdPrev & w_rdSync;
  assign w_unused = ^MCUportL[15:7];

  // r_fill marks when the last sync stage holds a real sample rather than the
  // reset value, so a read already in progress at reset release never arms.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync   <= '1;
      r_fill   <= '0;
      r_rdPrev <= 1'b1;
      r_arm    <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], w_rdGbl};
      r_fill   <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_rdPrev <= w_rdSync;
      if (w_rdSync && r_fill[SYNC_STAGES-1])
        r_arm <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // An end event during LOAD comes from a runt strobe; drop back to IDLE
  // without loading so nothing is left half-done.
  always_comb begin
    w_next   = r_state;
    w_latch  = 1'b0;
    w_load   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_latch = 1'b1;
          w_next  = LOAD;
        end
      end
      LOAD: begin
        if (w_end) begin
          w_next = IDLE;
        end else begin
          w_load = 1'b1;
          w_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (w_end) begin
          w_finish = 1'b1;
          w_next   = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_loadData = 8'h00;
    case (r_addr)
      4'd0: w_loadData = gBusy;
      4'd1: w_loadData = r_doneFlags;
      4'd2: w_loadData = gPosBus[7:0];
      4'd3: w_loadData = r_snap[15:8];
      4'd4: w_loadData = r_snap[23:16];
      4'd5: w_loadData = r_snap[31:24];
      4'd6: w_loadData = VERSION;
      default: w_loadData = 8'h00;
    endcase
  end

  assign w_clrMask = (w_finish && r_addr == 4'd1) ? r_dout : 8'h00;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr      <= 4'd0;
      r_posSel    <= 3'd0;
      r_dout      <= 8'h00;
      r_doutEn    <= 1'b0;
      r_doneFlags <= 8'h00;
      r_snap      <= 32'h0;
    end else begin
      if (w_latch) begin
        r_addr   <= MCUportL[3:0];
        r_posSel <= MCUportL[6:4];
      end
      if (w_load) begin
        r_dout   <= w_loadData;
        r_doutEn <= 1'b1;
        if (r_addr == 4'd2)
          r_snap <= gPosBus;
      end
      if (w_finish)
        r_doutEn <= 1'b0;
      r_doneFlags <= (r_doneFlags & ~w_clrMask) | gDonePls;
    end
  end

  assign gPosSel = r_posSel;
  assign Dout    = r_dout;
  assign DoutEn  = r_doutEn;

endmodule

// File: tb/tb_mcu_rd.sv
// Self-checking bench for mcu_rd: directed scenarios plus randomized reads
// checked against a register-level model of busy, done flags and snapshot.
module tb_mcu_rd;

  localparam int S = 2;

  logic        CLK;
  logic        RST;
  logic        CS;
  logic        RD;
  logic [15:0] MCUportL;
  logic [7:0]  gBusy;
  logic [7:0]  gDonePls;
  logic [31:0] gPosBus;
  logic [2:0]  gPosSel;
  logic [7:0]  Dout;
  logic        DoutEn;

  logic [31:0] posMem [8];
  logic [7:0]  doneModel;
  logic [31:0] snapModel;

  int checks;
  int failures;

  mcu_rd #(.SYNC_STAGES(S), .VERSION(8'hA5)) dut (
    .CLK(CLK), .RST(RST), .CS(CS), .RD(RD), .MCUportL(MCUportL),
    .gBusy(gBusy), .gDonePls(gDonePls), .gPosBus(gPosBus),
    .gPosSel(gPosSel), .Dout(Dout), .DoutEn(DoutEn)
  );

  assign gPosBus = posMem[gPosSel];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] m);
    @(posedge CLK); #1 gDonePls = m;
    @(posedge CLK); #1 gDonePls = 8'h00;
  endtask

  // Full MCU read; midP pulses during ACTIVE, endP lands on the clear cycle.
  task automatic mcuRead(input logic [3:0] addr, input logic [2:0] motor,
                         input logic [7:0] midP, input logic [7:0] endP,
                         output logic [7:0] data, output logic held,
                         output int rise, output int fall);
    logic [7:0] d0;
    @(posedge CLK); #1;
    MCUportL = {9'b0, motor, addr};
    CS = 1'b0;
    RD = 1'b0;
    rise = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK); #1;
      if (DoutEn === 1'b1) begin
        rise = k;
        break;
      end
    end
    d0   = Dout;
    held = 1'b1;
    for (int k = 1; k <= S + 3; k++) begin
      if (k == 1) gDonePls = midP;
      @(posedge CLK); #1;
      gDonePls = 8'h00;
      if (DoutEn !== 1'b1 || Dout !== d0) held = 1'b0;
    end
    data = d0;
    RD = 1'b1;
    CS = 1'b1;
    fall = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK); #1;
      gDonePls = (k == S) ? endP : 8'h00;
      if (DoutEn === 1'b0) begin
        fall = k;
        gDonePls = 8'h00;
        break;
      end
    end
    gDonePls = 8'h00;
    repeat (S + 3) @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] modelRead(input logic [3:0] addr, input logic [2:0] motor);
    logic [31:0] p;
    p = posMem[motor];
    case (addr)
      4'd0: return gBusy;
      4'd1: return doneModel;
      4'd2: return p[7:0];
      4'd3: return snapModel[15:8];
      4'd4: return snapModel[23:16];
      4'd5: return snapModel[31:24];
      4'd6: return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    logic [7:0] data;
    logic [7:0] exp;
    logic [3:0] a;
    logic [2:0] m;
    logic       held;
    logic       seen;
    int         rise;
    int         fall;

    checks    = 0;
    failures  = 0;
    doneModel = 8'h00;
    snapModel = 32'h0;
    for (int i = 0; i < 8; i++) posMem[i] = 32'h0;
    RST      = 1'b1;
    CS       = 1'b0;
    RD       = 1'b0;
    MCUportL = 16'h0000;
    gBusy    = 8'h00;
    gDonePls = 8'h00;

    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_DoutEn", DoutEn, 1'b0);
    checkOutput("rst_Dout", Dout, 8'h00);
    checkOutput("rst_gPosSel", gPosSel, 3'd0);
    RST  = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (DoutEn !== 1'b0) seen = 1'b1;
    end
    checkOutput("no_read_while_held_low", seen, 1'b0);
    RD = 1'b1;
    CS = 1'b1;
    repeat (S + 3) @(posedge CLK);

    gBusy = 8'h3C;
    mcuRead(4'd0, 3'd0, 8'h00, 8'h00, data, held, rise, fall);
    checkOutput("busy_data", data, 8'h3C);
    checkOutput("busy_held", held, 1'b1);
    checkOutput("rise_latency", rise, S + 2);
    checkOutput("fall_latency", fall, S + 1);

    applyStimulus(8'h21);
    doneModel |= 8'h21;
    mcuRead(4'd1, 3'd0, 8'h00, 8'h00, data, held, rise, fall);
    checkOutput("done_read", data, 8'h21);
    doneModel &= ~data;
    mcuRead(4'd1, 3'd0, 8'h00, 8'h00, data, held, rise, fall);
    checkOutput("done_cleared", data, 8'h00);

    applyStimulus(8'h01);
    doneModel = 8'h01;
    mcuRead(4'd1, 3'd0, 8'h04, 8'h00, data, held, rise, fall);
    checkOutput("done_pre_mid", data, 8'h01);
    doneModel = (doneModel & ~data) | 8'h04;
    checkOutput("done_after_mid", dut.r_doneFlags, doneModel);
    mcuRead(4'd1, 3'd0, 8'h00, 8'h00, data, held, rise, fall);
    checkOutput("done_mid_kept", data, 8'h04);
    doneModel = 8'h00;
    applyStimulus(8'h01);
    doneModel = 8'h01;
    mcuRead(4'd1, 3'd0, 8'h00, 8'h01, data, held, rise, fall);
    checkOutput("done_pre_coinc", data, 8'h01);
    mcuRead(4'd1, 3'd0, 8'h00, 8'h00, data, held, rise, fall);
    checkOutput("done_set_wins", data, 8'h01);
    doneModel = 8'h00;

    posMem[3] = 32'h12345678;
    mcuRead(4'd2, 3'd3, 8'h00, 8'h00, data, held, rise, fall);
    checkOutput("pos_sel", gPosSel, 3'd3);
    checkOutput("pos_b0", data, 8'h78);
    snapModel = 32'h12345678;
    posMem[3] = 32'hFFFFFFFF;
    mcuRead(4'd3, 3'd3, 8'h00, 8'h00, data, held, rise, fall);
    checkOutput("pos_b1", data, 8'h56);
    mcuRead(4'd4, 3'd3, 8'h00, 8'h00, data, held, rise, fall);
    checkOutput("pos_b2", data, 8'h34);
    mcuRead(4'd5, 3'd3, 8'h00, 8'h00, data, held, rise, fall);
    checkOutput("pos_b3", data, 8'h12);

    mcuRead(4'd6, 3'd0, 8'h00, 8'h00, data, held, rise, fall);
    checkOutput("version", data, 8'hA5);
    checkOutput("version_rise", rise, S + 2);
    mcuRead(4'd9, 3'd0, 8'h00, 8'h00, data, held, rise, fall);
    checkOutput("unmapped", data, 8'h00);
    checkOutput("unmapped_fall", fall, S + 1);

    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          exp = 8'($urandom);
          applyStimulus(exp);
          doneModel |= exp;
        end
        1: posMem[$urandom_range(0, 7)] = $urandom;
        default: gBusy = 8'($urandom);
      endcase
      a   = 4'($urandom_range(0, 15));
      m   = 3'($urandom_range(0, 7));
      exp = modelRead(a, m);
      if (a == 4'd2) snapModel = posMem[m];
      mcuRead(a, m, 8'h00, 8'h00, data, held, rise, fall);
      checkOutput($sformatf("rand%0d_a%0d", it, a), data, exp);
      checkOutput($sformatf("rand%0d_held", it), held, 1'b1);
      checkOutput($sformatf("rand%0d_sel", it), gPosSel, m);
      if (a == 4'd1) doneModel &= ~exp;
    end

    applyStimulus(8'hFF);
    @(posedge CLK); #1;
    MCUportL = 16'h0001;
    CS = 1'b0;
    RD = 1'b0;
    repeat (S + 4) @(posedge CLK);
    #1;
    checkOutput("rst_mid_active", DoutEn, 1'b1);
    RST = 1'b1;
    @(posedge CLK); #1;
    checkOutput("rst_mid_DoutEn", DoutEn, 1'b0);
    checkOutput("rst_mid_done", dut.r_doneFlags, 8'h00);
    RST  = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (DoutEn !== 1'b0) seen = 1'b1;
    end
    checkOutput("rst_mid_no_reaccept", seen, 1'b0);
    RD = 1'b1;
    CS = 1'b1;
    repeat (S + 3) @(posedge CLK);
    doneModel = 8'h00;
    mcuRead(4'd1, 3'd0, 8'h00, 8'h00, data, held, rise, fall);
    checkOutput("post_rst_read", data, doneModel);
    checkOutput("post_rst_rise", rise, S + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
